// File: rtl/dsp_bus_interface.sv
// DSP asynchronous bus front-end: synchronizes and qualifies the DSP strobes, latches
// address/write data for the xclk-domain peripherals and muxes their read data back.
module dsp_bus_interface #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned QUAL_CYCLES  = 2,
  parameter logic [15:0] DEFAULT_READ = 16'hFFFF
) (
  input  logic        xclk,
  input  logic        reset,
  input  logic        dsp_cs_n,
  input  logic        dsp_rd_n,
  input  logic        dsp_wr_n,
  input  logic [7:0]  dsp_addr,
  input  logic [15:0] dsp_db_in,
  input  logic [15:0] db_out_MT,
  input  logic        data_from_MT_avail,
  input  logic [15:0] db_out_app,
  input  logic        data_from_app_avail,
  output logic [7:0]  ab,
  output logic [15:0] db_in,
  output logic        write_qualified,
  output logic        read_qualified,
  output logic [15:0] dsp_db_out,
  output logic        dsp_db_oe,
  output logic [7:0]  glitch_count,
  output logic        bus_conflict
);

  localparam logic [3:0] QualCnt = 4'(QUAL_CYCLES);

  typedef enum logic [2:0] {StIdle, StQual, StWrite, StRead, StRelease} state_e;

  // Synchronizers
  logic [SYNC_STAGES-1:0] cs_sync_q, rd_sync_q, wr_sync_q;

  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) begin
      cs_sync_q <= '1;
      rd_sync_q <= '1;
      wr_sync_q <= '1;
    end else begin
      cs_sync_q <= {cs_sync_q[SYNC_STAGES-2:0], dsp_cs_n};
      rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], dsp_rd_n};
      wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], dsp_wr_n};
    end
  end

  logic cs_s, rd_s, wr_s;
  logic rd_act, wr_act, both;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign rd_s   = rd_sync_q[SYNC_STAGES-1];
  assign wr_s   = wr_sync_q[SYNC_STAGES-1];
  assign rd_act = !cs_s && !rd_s && wr_s;
  assign wr_act = !cs_s && !wr_s && rd_s;
  assign both   = !cs_s && !rd_s && !wr_s;

  // FSM state register
  state_e     state_q, state_d;
  logic [3:0] qual_cnt_q, qual_cnt_d;
  logic       is_wr_q, is_wr_d;

  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      qual_cnt_q <= '0;
      is_wr_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      qual_cnt_q <= qual_cnt_d;
      is_wr_q    <= is_wr_d;
    end
  end

  // FSM next-state logic
  logic cur_act;
  logic latch_en;
  logic glitch_seen;

  assign cur_act = is_wr_q ? wr_act : rd_act;

  always_comb begin
    state_d     = state_q;
    qual_cnt_d  = qual_cnt_q;
    is_wr_d     = is_wr_q;
    latch_en    = 1'b0;
    glitch_seen = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rd_act || wr_act) begin
          qual_cnt_d = 4'd1;
          is_wr_d    = wr_act;
          state_d    = StQual;
        end
      end
      StQual: begin
        // Release, direction change and rd+wr together all abort the qualification.
        if (!cur_act) begin
          glitch_seen = 1'b1;
          state_d     = StIdle;
        end else if (qual_cnt_q == QualCnt) begin
          latch_en = 1'b1;
          state_d  = is_wr_q ? StWrite : StRead;
        end else begin
          qual_cnt_d = qual_cnt_q + 4'd1;
        end
      end
      StWrite: begin
        if (!wr_act) state_d = StRelease;
      end
      StRead: begin
        if (!rd_act) state_d = StRelease;
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output next-state logic
  logic [7:0]  ab_q, ab_d;
  logic [15:0] db_in_q, db_in_d;
  logic        wq_q, wq_d;
  logic        rq_q, rq_d;
  logic        oe_q, oe_d;
  logic [15:0] db_out_q, db_out_d;
  logic [7:0]  glitch_q, glitch_d;
  logic        conflict_q, conflict_d;
  logic [15:0] read_mux;

  always_comb begin
    if (data_from_MT_avail) begin
      read_mux = db_out_MT;
    end else if (data_from_app_avail) begin
      read_mux = db_out_app;
    end else begin
      read_mux = DEFAULT_READ;
    end
  end

  always_comb begin
    ab_d       = latch_en ? dsp_addr : ab_q;
    db_in_d    = (latch_en && is_wr_q) ? dsp_db_in : db_in_q;
    wq_d       = (state_d == StWrite);
    rq_d       = (state_d == StRead);
    oe_d       = (state_d == StRead);
    db_out_d   = db_out_q;
    glitch_d   = glitch_q;
    conflict_d = conflict_q | both;
    // Peripherals answer one cycle after read_qualified, so the entry cycle drives the default.
    if (state_d == StRead) begin
      db_out_d = (state_q == StRead) ? read_mux : DEFAULT_READ;
    end
    if (glitch_seen && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) begin
      ab_q       <= '0;
      db_in_q    <= '0;
      wq_q       <= 1'b0;
      rq_q       <= 1'b0;
      oe_q       <= 1'b0;
      db_out_q   <= '0;
      glitch_q   <= '0;
      conflict_q <= 1'b0;
    end else begin
      ab_q       <= ab_d;
      db_in_q    <= db_in_d;
      wq_q       <= wq_d;
      rq_q       <= rq_d;
      oe_q       <= oe_d;
      db_out_q   <= db_out_d;
      glitch_q   <= glitch_d;
      conflict_q <= conflict_d;
    end
  end

  assign ab              = ab_q;
  assign db_in           = db_in_q;
  assign write_qualified = wq_q;
  assign read_qualified  = rq_q;
  assign dsp_db_oe       = oe_q;
  assign dsp_db_out      = db_out_q;
  assign glitch_count    = glitch_q;
  assign bus_conflict    = conflict_q;

endmodule

// File: tb/tb_dsp_bus_interface.sv
// Directed self-checking bench for dsp_bus_interface: writes, reads, glitches, conflicts, reset.
module tb_dsp_bus_interface;

  localparam int unsigned SYNC = 2;
  localparam int unsigned QUAL = 2;
  localparam int HOLD = 6;
  // Synchronizer, IDLE detect, QUAL count, then the registered qualified output.
  localparam int FIRST_Q = SYNC + QUAL + 1;
  // Released after HOLD samples; cleared the cycle after the synchronized release.
  localparam int LAST_Q = HOLD + SYNC;

  logic        xclk = 1'b0;
  logic        reset = 1'b0;
  logic        dsp_cs_n = 1'b1, dsp_rd_n = 1'b1, dsp_wr_n = 1'b1;
  logic [7:0]  dsp_addr = '0;
  logic [15:0] dsp_db_in = '0;
  logic [15:0] db_out_MT = 16'h1234;
  logic        data_from_MT_avail;
  logic [15:0] db_out_app = 16'h5555;
  logic        data_from_app_avail;
  logic [7:0]  ab;
  logic [15:0] db_in;
  logic        write_qualified, read_qualified;
  logic [15:0] dsp_db_out;
  logic        dsp_db_oe;
  logic [7:0]  glitch_count;
  logic        bus_conflict;
  logic        mt_en = 1'b0, app_en = 1'b0;

  int checks = 0;
  int failures = 0;

  dsp_bus_interface #(
    .SYNC_STAGES (SYNC),
    .QUAL_CYCLES (QUAL),
    .DEFAULT_READ(16'hFFFF)
  ) dut (
    .xclk               (xclk),
    .reset              (reset),
    .dsp_cs_n           (dsp_cs_n),
    .dsp_rd_n           (dsp_rd_n),
    .dsp_wr_n           (dsp_wr_n),
    .dsp_addr           (dsp_addr),
    .dsp_db_in          (dsp_db_in),
    .db_out_MT          (db_out_MT),
    .data_from_MT_avail (data_from_MT_avail),
    .db_out_app         (db_out_app),
    .data_from_app_avail(data_from_app_avail),
    .ab                 (ab),
    .db_in              (db_in),
    .write_qualified    (write_qualified),
    .read_qualified     (read_qualified),
    .dsp_db_out         (dsp_db_out),
    .dsp_db_oe          (dsp_db_oe),
    .glitch_count       (glitch_count),
    .bus_conflict       (bus_conflict)
  );

  always #5 xclk = ~xclk;

  // Peripheral models: claim a read one cycle after read_qualified.
  always @(posedge xclk or negedge reset) begin
    if (!reset) begin
      data_from_MT_avail  <= 1'b0;
      data_from_app_avail <= 1'b0;
    end else begin
      data_from_MT_avail  <= mt_en & read_qualified;
      data_from_app_avail <= app_en & read_qualified;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_access(input bit is_wr, input logic [7:0] a, input logic [15:0] d,
                           output int first_q, output int last_q, output bit other,
                           output bit oe_bad, output logic [15:0] db_first,
                           output logic [15:0] db_last);
    logic q;
    first_q  = -1;
    last_q   = -1;
    other    = 1'b0;
    oe_bad   = 1'b0;
    db_first = '0;
    db_last  = '0;
    @(negedge xclk);
    dsp_addr  = a;
    dsp_db_in = d;
    dsp_cs_n  = 1'b0;
    if (is_wr) dsp_wr_n = 1'b0;
    else dsp_rd_n = 1'b0;
    for (int i = 1; i <= HOLD + 10; i++) begin
      @(negedge xclk);
      q = is_wr ? write_qualified : read_qualified;
      if (q) begin
        if (first_q < 0) begin
          first_q  = i;
          db_first = dsp_db_out;
        end
        last_q  = i;
        db_last = dsp_db_out;
      end
      if (is_wr ? read_qualified : write_qualified) other = 1'b1;
      if (dsp_db_oe !== read_qualified) oe_bad = 1'b1;
      if (i == HOLD) begin
        dsp_cs_n = 1'b1;
        dsp_rd_n = 1'b1;
        dsp_wr_n = 1'b1;
      end
    end
  endtask

  task automatic wr_glitch(output bit seen);
    seen = 1'b0;
    @(negedge xclk);
    dsp_cs_n = 1'b0;
    dsp_wr_n = 1'b0;
    @(negedge xclk);
    dsp_cs_n = 1'b1;
    dsp_wr_n = 1'b1;
    repeat (4) begin
      @(negedge xclk);
      if (write_qualified || read_qualified) seen = 1'b1;
    end
  endtask

  initial begin
    int          fq, lq;
    bit          oth, oeb, seen, any_seen;
    logic [15:0] dbf, dbl;

    repeat (3) @(negedge xclk);
    check_eq("rst_outputs", {ab, write_qualified, read_qualified, dsp_db_oe, glitch_count,
                             bus_conflict}, '0);
    check_eq("rst_db", {db_in, dsp_db_out}, '0);
    reset = 1'b1;
    repeat (2) @(negedge xclk);

    do_access(1'b1, 8'h05, 16'h0002, fq, lq, oth, oeb, dbf, dbl);
    check_eq("wr_first", fq, FIRST_Q);
    check_eq("wr_last", lq, LAST_Q);
    check_eq("wr_no_rq", oth, 0);
    check_eq("wr_ab", ab, 8'h05);
    check_eq("wr_db_in", db_in, 16'h0002);
    check_eq("wr_oe", {oeb, dsp_db_oe}, 0);

    mt_en = 1'b1;
    do_access(1'b0, 8'h10, 16'h0000, fq, lq, oth, oeb, dbf, dbl);
    mt_en = 1'b0;
    check_eq("rd_first", fq, FIRST_Q);
    check_eq("rd_last", lq, LAST_Q);
    check_eq("rd_no_wq", oth, 0);
    check_eq("rd_ab", ab, 8'h10);
    check_eq("rd_db_in_kept", db_in, 16'h0002);
    check_eq("rd_mt_first", dbf, 16'hFFFF);
    check_eq("rd_mt_data", dbl, 16'h1234);
    check_eq("rd_oe_window", oeb, 0);
    check_eq("rd_hold", {dsp_db_out, dsp_db_oe}, {16'h1234, 1'b0});

    do_access(1'b0, 8'h20, 16'h0000, fq, lq, oth, oeb, dbf, dbl);
    check_eq("rd_none_first", dbf, 16'hFFFF);
    check_eq("rd_none_last", dbl, 16'hFFFF);

    mt_en     = 1'b1;
    app_en    = 1'b1;
    db_out_MT = 16'hAAAA;
    do_access(1'b0, 8'h21, 16'h0000, fq, lq, oth, oeb, dbf, dbl);
    mt_en  = 1'b0;
    app_en = 1'b0;
    check_eq("rd_prio", dbl, 16'hAAAA);

    app_en = 1'b1;
    do_access(1'b0, 8'h22, 16'h0000, fq, lq, oth, oeb, dbf, dbl);
    app_en = 1'b0;
    check_eq("rd_app", dbl, 16'h5555);

    check_eq("glitch_init", glitch_count, 8'h00);
    wr_glitch(seen);
    check_eq("glitch_noq", seen, 0);
    check_eq("glitch_one", glitch_count, 8'h01);
    any_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      wr_glitch(seen);
      any_seen |= seen;
    end
    check_eq("glitch_sat", glitch_count, 8'hFF);
    check_eq("glitch_sat_noq", any_seen, 0);
    check_eq("conflict_clear", bus_conflict, 0);

    @(negedge xclk);
    dsp_cs_n = 1'b0;
    dsp_rd_n = 1'b0;
    dsp_wr_n = 1'b0;
    any_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge xclk);
      if (write_qualified || read_qualified || dsp_db_oe) any_seen = 1'b1;
      if (i == 3) begin
        dsp_cs_n = 1'b1;
        dsp_rd_n = 1'b1;
        dsp_wr_n = 1'b1;
      end
    end
    check_eq("conflict_set", bus_conflict, 1);
    check_eq("conflict_noq", any_seen, 0);

    do_access(1'b1, 8'h33, 16'hBEEF, fq, lq, oth, oeb, dbf, dbl);
    check_eq("post_conf_first", fq, FIRST_Q);
    check_eq("post_conf_data", {ab, db_in}, {8'h33, 16'hBEEF});
    check_eq("conflict_sticky", bus_conflict, 1);

    // Reset in the middle of a read.
    mt_en = 1'b1;
    @(negedge xclk);
    dsp_addr = 8'h44;
    dsp_cs_n = 1'b0;
    dsp_rd_n = 1'b0;
    for (int i = 0; i < 20 && !read_qualified; i++) @(negedge xclk);
    check_eq("mid_rd_active", read_qualified, 1);
    repeat (3) @(negedge xclk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_rst_ctl", {write_qualified, read_qualified, dsp_db_oe, glitch_count,
                               bus_conflict}, '0);
    check_eq("async_rst_data", {ab, dsp_db_out}, '0);
    check_eq("async_rst_db_in", db_in, '0);
    dsp_cs_n = 1'b1;
    dsp_rd_n = 1'b1;
    mt_en    = 1'b0;
    @(negedge xclk);
    reset    = 1'b1;
    any_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge xclk);
      if (write_qualified || read_qualified || dsp_db_oe) any_seen = 1'b1;
    end
    check_eq("post_rst_quiet", any_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
